// File: rtl/banked_ram_ctrl.sv
`timescale 1ns/1ps
// banked_ram_ctrl
// Word-addressed RAM split into NBANK banks selected by the top address bits.
// After reset the controller sweeps every in-bank index once, writing zero to
// all banks in parallel, then serves single-cycle reads and byte-lane writes.
//
// Handshake: a request is taken on a rising edge where req=1 and ready=1.
// ready is never conditioned on req; a request presented while ready=0 is
// dropped (not held, not queued). A taken read returns exactly one rvalid
// pulse one cycle later, with rdata and rbank valid only while rvalid=1.
// A taken write never produces rvalid.
//
// busy mirrors the FSM state (1 = CLEAR, 0 = RUN) and doubles as the state
// observation point.

module banked_ram_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int BANK_BITS = 2,
    parameter int LANE_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic                       rw,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/LANE_W-1:0]   be,
    output logic                       ready,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rvalid,
    output logic [BANK_BITS-1:0]       rbank,
    output logic                       busy
);

    localparam int NBANK = 1 << BANK_BITS;
    localparam int NLANE = DATA_W / LANE_W;
    localparam int IDX_W = ADDR_W - BANK_BITS;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic               rvalid_q;
    logic [BANK_BITS-1:0] rbank_q;

    logic [BANK_BITS-1:0] bank_sel;
    logic [IDX_W-1:0]   idx;
    logic               accept;
    logic               wr_acc;
    logic               rd_acc;
    logic               clr_en;
    logic [DATA_W-1:0]  bank_rdata [NBANK];

    // Address split: top bits choose the bank, the rest index inside it.
    assign bank_sel = addr[ADDR_W-1 -: BANK_BITS];
    assign idx      = addr[IDX_W-1:0];

    // Reset forces the not-ready view immediately, so nothing is taken on a reset edge.
    assign ready  = (state_q == ST_RUN) && !rst;
    assign busy   = (state_q == ST_CLEAR) || rst;

    assign accept = req && ready;
    assign wr_acc = accept && rw;
    assign rd_acc = accept && !rw;

    // The sweep only advances on non-reset edges so a held reset keeps the pointer at 0.
    assign clr_en = (state_q == ST_CLEAR) && !rst;

    // Next-state and clear-pointer logic.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    clr_ptr_d = clr_ptr_q + IDX_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // FSM state and clear pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Read response tracking: one pulse per taken read, plus the serving bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rbank_q  <= '0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) begin
                rbank_q <= bank_sel;
            end
        end
    end

    // A reset arriving right after a read acceptance suppresses that pulse.
    assign rvalid = rvalid_q && !rst;
    assign rbank  = rst ? '0 : rbank_q;

    // rdata follows the read register of the last bank that served a read;
    // that register only changes on a read to its own bank, so rdata holds.
    assign rdata  = bank_rdata[rbank_q];

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [DATA_W-1:0] rd_q;
        logic              sel;
        logic              bank_wr;
        logic              bank_rd;

        assign sel     = (bank_sel == BANK_BITS'(b));
        assign bank_wr = wr_acc && sel;
        assign bank_rd = rd_acc && sel;

        // Storage write port: clear sweep in CLEAR, lane-masked writes in RUN.
        always_ff @(posedge clk) begin
            if (clr_en) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (bank_wr) begin
                for (int k = 0; k < NLANE; k++) begin
                    if (be[k]) begin
                        mem_q[idx][k*LANE_W +: LANE_W] <= wdata[k*LANE_W +: LANE_W];
                    end
                end
            end
        end

        // Per-bank read register, loaded only when this bank serves a read.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
            end else if (bank_rd) begin
                rd_q <= mem_q[idx];
            end
        end

        assign bank_rdata[b] = rd_q;
    end

endmodule
